// File: rtl/addr_router.sv
// addr_router: routes each input beat to one of NUM_CH first-word-fall-through FIFOs,
// selected by the top CH_W bits of the beat address.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset; clears all counts and pointers
//   valid      input beat present
//   ready      FIFO selected by addr_in is not full (independent of valid)
//   addr_in    beat address; top CH_W bits choose the channel
//   data_in    beat data
//   out_valid  per-channel beat present (bit c = channel c)
//   out_ready  per-channel consumer accepts the head beat
//   addr_out   head address per channel, [c*ADDR_W +: ADDR_W], zero while empty
//   data_out   head data per channel, [c*DATA_W +: DATA_W], zero while empty
//   ch_count   per-channel occupancy 0..DEPTH, [c*CNT_W +: CNT_W]
module addr_router #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned CH_W  = $clog2(NUM_CH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid,
    output logic                     ready,
    input  logic [ADDR_W-1:0]        addr_in,
    input  logic [DATA_W-1:0]        data_in,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*ADDR_W-1:0] addr_out,
    output logic [NUM_CH*DATA_W-1:0] data_out,
    output logic [NUM_CH*CNT_W-1:0]  ch_count
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned BEAT_W = ADDR_W + DATA_W;

    logic [CH_W-1:0]   sel;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;

    assign sel = addr_in[ADDR_W-1 -: CH_W];

    // A full FIFO never accepts, even when it pops on the same edge.
    assign ready = ~full[sel];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [BEAT_W-1:0] mem_q [DEPTH];
        logic [PTR_W-1:0]  wptr_q, wptr_d;
        logic [PTR_W-1:0]  rptr_q, rptr_d;
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        logic [BEAT_W-1:0] head;

        assign push[c] = valid && ready && (sel == CH_W'(c));
        assign pop[c]  = out_valid[c] && out_ready[c];

        always_comb begin
            wptr_d = wptr_q;
            rptr_d = rptr_q;
            cnt_d  = cnt_q;
            if (push[c]) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (pop[c]) begin
                rptr_d = rptr_q + 1'b1;
            end
            if (push[c] && !pop[c]) begin
                cnt_d = cnt_q + 1'b1;
            end else if (!push[c] && pop[c]) begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                wptr_q <= wptr_d;
                rptr_q <= rptr_d;
                cnt_q  <= cnt_d;
            end
        end

        // Storage is not reset; a write during reset is harmless since the pointers clear.
        always_ff @(posedge clk) begin
            if (push[c]) begin
                mem_q[wptr_q] <= {addr_in, data_in};
            end
        end

        assign head         = mem_q[rptr_q];
        assign full[c]      = (cnt_q == CNT_W'(DEPTH));
        assign out_valid[c] = (cnt_q != '0);

        assign addr_out[c*ADDR_W +: ADDR_W] = out_valid[c] ? head[BEAT_W-1 -: ADDR_W] : '0;
        assign data_out[c*DATA_W +: DATA_W] = out_valid[c] ? head[DATA_W-1:0] : '0;
        assign ch_count[c*CNT_W +: CNT_W]   = cnt_q;
    end

endmodule

// File: tb/tb_addr_router.sv
// tb_addr_router: self-checking bench for addr_router. A queue-per-channel model predicts
// every output each cycle; directed sequences pin routing, fill, order/wrap, simultaneous
// push/pop, reset and a small-parameter instance.
module tb_addr_router;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic        ready;
    logic [7:0]  addr_in;
    logic [15:0] data_in;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] addr_out;
    logic [63:0] data_out;
    logic [11:0] ch_count;

    // Small instance: NUM_CH=2, DEPTH=2, ADDR_W=6, DATA_W=8 (CNT_W=2).
    logic        s_valid;
    logic        s_ready;
    logic [5:0]  s_addr;
    logic [7:0]  s_data;
    logic [1:0]  s_out_valid;
    logic [1:0]  s_out_ready;
    logic [11:0] s_addr_out;
    logic [15:0] s_data_out;
    logic [3:0]  s_ch_count;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    addr_router dut (
        .clk       (clk),
        .reset     (reset),
        .valid     (valid),
        .ready     (ready),
        .addr_in   (addr_in),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .addr_out  (addr_out),
        .data_out  (data_out),
        .ch_count  (ch_count)
    );

    addr_router #(
        .ADDR_W (6),
        .DATA_W (8),
        .NUM_CH (2),
        .DEPTH  (2)
    ) dut_s (
        .clk       (clk),
        .reset     (reset),
        .valid     (s_valid),
        .ready     (s_ready),
        .addr_in   (s_addr),
        .data_in   (s_data),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .addr_out  (s_addr_out),
        .data_out  (s_data_out),
        .ch_count  (s_ch_count)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one queue of {addr,data} per channel.
    logic [23:0] mq [4][$];
    bit          live = 1'b0;

    always @(posedge clk) begin
        int       sz [4];
        int       s;
        for (int c = 0; c < 4; c++) sz[c] = mq[c].size();
        if (reset) begin
            for (int c = 0; c < 4; c++) mq[c].delete();
            live = 1'b1;
        end else begin
            s = int'(addr_in) / 64;
            for (int c = 0; c < 4; c++) begin
                if (sz[c] > 0 && out_ready[c]) void'(mq[c].pop_front());
            end
            if (valid && sz[s] < 4) mq[s].push_back({addr_in, data_in});
        end
    end

    always @(negedge clk) begin
        logic [3:0]  e_v;
        logic [31:0] e_a;
        logic [63:0] e_d;
        logic [11:0] e_n;
        logic [23:0] h;
        int          s;
        if (live) begin
            e_v = '0;
            e_a = '0;
            e_d = '0;
            e_n = '0;
            for (int c = 0; c < 4; c++) begin
                e_n[c*3 +: 3] = 3'(mq[c].size());
                if (mq[c].size() > 0) begin
                    h = mq[c][0];
                    e_v[c] = 1'b1;
                    e_a[c*8 +: 8]   = h[23:16];
                    e_d[c*16 +: 16] = h[15:0];
                end
            end
            s = int'(addr_in) / 64;
            chk("model ready", 64'(ready), 64'(mq[s].size() < 4));
            chk("model out_valid", 64'(out_valid), 64'(e_v));
            chk("model addr_out", 64'(addr_out), 64'(e_a));
            chk("model data_out", data_out, e_d);
            chk("model ch_count", 64'(ch_count), 64'(e_n));
        end
    end

    initial begin
        logic [7:0] route_a [4];
        int         got [$];
        int         nxt;
        bit         tog;
        bit         hold;

        reset = 1'b1;
        valid = 1'b0;
        addr_in = '0;
        data_in = '0;
        out_ready = '0;
        s_valid = 1'b0;
        s_addr = '0;
        s_data = '0;
        s_out_ready = '0;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("reset out_valid", 64'(out_valid), 64'h0);
        chk("reset ch_count", 64'(ch_count), 64'h0);
        chk("reset ready", 64'(ready), 64'h1);
        tick();

        // Routing of the four boundary addresses.
        route_a[0] = 8'h3F;
        route_a[1] = 8'h40;
        route_a[2] = 8'hBF;
        route_a[3] = 8'hC0;
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1;
            addr_in = route_a[i];
            data_in = 16'h1234 + 16'(i);
            tick();
            valid = 1'b0;
            @(negedge clk);
            chk("route out_valid", 64'(out_valid), 64'(4'b0001 << i));
            chk("route addr_out", 64'(addr_out[i*8 +: 8]), 64'(route_a[i]));
            chk("route data_out", 64'(data_out[i*16 +: 16]), 64'(16'h1234 + 16'(i)));
            out_ready = '1;
            tick();
            out_ready = '0;
        end

        // Fill ch0: fifth beat refused, other channel still accepted.
        for (int i = 0; i < 5; i++) begin
            valid = 1'b1;
            addr_in = 8'h10;
            data_in = 16'h0100 + 16'(i);
            tick();
        end
        @(negedge clk);
        chk("fill ch0 count", 64'(ch_count[2:0]), 64'd4);
        chk("fill ready low", 64'(ready), 64'h0);
        addr_in = 8'h50;
        data_in = 16'h0200;
        #1;
        chk("fill ch1 ready", 64'(ready), 64'h1);
        tick();
        valid = 1'b0;
        @(negedge clk);
        chk("fill ch1 count", 64'(ch_count[5:3]), 64'd1);
        chk("fill ch0 head", 64'(data_out[15:0]), 64'h0100);
        out_ready = '1;
        repeat (6) tick();
        out_ready = '0;

        // Order and pointer wrap on ch2 with alternating out_ready.
        nxt = 1;
        tog = 1'b1;
        for (int cyc = 0; cyc < 200 && got.size() < 10; cyc++) begin
            valid = (nxt <= 10);
            addr_in = 8'h80;
            data_in = 16'(nxt);
            out_ready = tog ? 4'b0100 : 4'b0000;
            @(negedge clk);
            if (out_valid[2] && out_ready[2]) got.push_back(int'(data_out[47:32]));
            if (valid && ready) nxt++;
            tog = !tog;
            tick();
        end
        valid = 1'b0;
        out_ready = '0;
        chk("order pop count", 64'(got.size()), 64'd10);
        for (int i = 0; i < got.size(); i++) chk("order data", 64'(got[i]), 64'(i + 1));
        @(negedge clk);
        chk("order final count", 64'(ch_count[8:6]), 64'd0);
        tick();

        // Simultaneous push and pop on ch3.
        valid = 1'b1;
        addr_in = 8'hC0;
        data_in = 16'h00A1;
        tick();
        data_in = 16'h00A2;
        tick();
        data_in = 16'h00A3;
        out_ready = 4'b1000;
        tick();
        valid = 1'b0;
        out_ready = '0;
        @(negedge clk);
        chk("simul ch3 count", 64'(ch_count[11:9]), 64'd2);
        chk("simul ch3 head", 64'(data_out[63:48]), 64'h00A2);
        out_ready = 4'b1000;
        tick();
        @(negedge clk);
        chk("simul third beat", 64'(data_out[63:48]), 64'h00A3);
        tick();
        out_ready = '0;

        // Reset mid-run with a beat presented on the reset edge.
        valid = 1'b1;
        addr_in = 8'h00;
        data_in = 16'h0011;
        tick();
        data_in = 16'h0012;
        tick();
        addr_in = 8'h40;
        data_in = 16'h0021;
        tick();
        reset = 1'b1;
        addr_in = 8'h00;
        data_in = 16'hDEAD;
        tick();
        reset = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        chk("rst out_valid", 64'(out_valid), 64'h0);
        chk("rst ch_count", 64'(ch_count), 64'h0);
        chk("rst ready", 64'(ready), 64'h1);
        out_ready = '1;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("rst beat gone", 64'(out_valid), 64'h0);
        end
        tick();
        out_ready = '0;

        // Randomized traffic, holding a refused beat stable.
        hold = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!hold) begin
                valid = ($urandom_range(0, 3) != 0);
                addr_in = 8'($urandom);
                data_in = 16'($urandom);
            end
            if (cyc < 1500) out_ready = 4'($urandom & $urandom);
            else out_ready = 4'($urandom | $urandom);
            reset = ($urandom_range(0, 299) == 0);
            @(negedge clk);
            hold = valid && !ready && !reset;
            tick();
        end
        reset = 1'b0;
        valid = 1'b0;
        out_ready = '0;
        tick();

        // Small-parameter instance.
        s_valid = 1'b1;
        s_addr = 6'h1F;
        s_data = 8'h5A;
        tick();
        s_addr = 6'h20;
        s_data = 8'hA5;
        tick();
        s_valid = 1'b0;
        @(negedge clk);
        chk("sweep out_valid", 64'(s_out_valid), 64'h3);
        chk("sweep ch0 addr", 64'(s_addr_out[5:0]), 64'h1F);
        chk("sweep ch1 addr", 64'(s_addr_out[11:6]), 64'h20);
        chk("sweep ch1 data", 64'(s_data_out[15:8]), 64'hA5);
        s_valid = 1'b1;
        s_addr = 6'h1F;
        s_data = 8'h66;
        tick();
        @(negedge clk);
        chk("sweep ch0 full count", 64'(s_ch_count[1:0]), 64'd2);
        chk("sweep ch0 ready low", 64'(s_ready), 64'h0);
        s_addr = 6'h20;
        #1;
        chk("sweep ch1 ready", 64'(s_ready), 64'h1);
        s_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
